grid_mem_arbiter: RTL and testbench

- Arbiter and sequencer in front of the single-port 1-bit grid cell SRAM (30x40 = 1200 cells, one read or one write per cycle, read data one cycle after address).
- Shares the SRAM between two requesters: the video scanout reader and the cell-update logic (read/write).
- Also runs a whole-grid clear sequence on command.
- Sits between those requesters and the SRAM instance; it is the only driver of the SRAM control inputs.

---
 rtl/grid_mem_arbiter.sv | 150 +++++++++++++++
 tb/tb_grid_mem_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/grid_mem_arbiter.sv
// Arbiter and clear sequencer for the single-port 1-bit grid cell SRAM (video reads, logic read/write, whole-grid clear).
// Optional macro GRID_ARB_FAIRNESS_EN bounds how long video may starve the logic port.
module grid_mem_arbiter #(
  parameter int DEPTH      = 1200,
  parameter int ADDR_WIDTH = 11,
  parameter int MAX_STARVE = 8
) (
  input  logic                  clk_74a,
  input  logic                  reset,
  input  logic                  vid_req,
  input  logic [ADDR_WIDTH-1:0] vid_addr,
  output logic                  vid_gnt,
  output logic                  vid_valid,
  output logic                  vid_data,
  input  logic                  lg_req,
  input  logic                  lg_we,
  input  logic [ADDR_WIDTH-1:0] lg_addr,
  input  logic                  lg_wdata,
  output logic                  lg_gnt,
  output logic                  lg_rvalid,
  output logic                  lg_rdata,
  input  logic                  clr_start,
  output logic                  clr_busy,
  output logic                  clr_done,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_data_in,
  input  logic                  mem_data_out
);

  typedef enum logic [0:0] {ST_IDLE, ST_CLEAR} state_t;

  localparam logic [ADDR_WIDTH:0]   LP_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LP_LAST  = ADDR_WIDTH'(DEPTH - 1);

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_clrCnt;
  logic                  r_clrBusy;
  logic                  r_clrDone;
  logic                  r_vidValid;
  logic                  r_vidOor;
  logic                  r_lgValid;
  logic                  r_lgOor;
  logic                  w_vidInRange;
  logic                  w_lgInRange;
  logic                  w_fairForce;

  assign w_vidInRange = ({1'b0, vid_addr} < LP_DEPTH);
  assign w_lgInRange  = ({1'b0, lg_addr} < LP_DEPTH);

`ifdef GRID_ARB_FAIRNESS_EN
  localparam int SW = $clog2(MAX_STARVE + 1);
  logic [SW-1:0] r_starve;

  assign w_fairForce = (r_state == ST_IDLE) && lg_req && (r_starve >= SW'(MAX_STARVE));

  // Consecutive IDLE cycles in which logic waited behind a video grant
  always_ff @(posedge clk_74a) begin
    if (reset) begin
      r_starve <= '0;
    end else if ((r_state != ST_IDLE) || !lg_req || lg_gnt) begin
      r_starve <= '0;
    end else if (vid_gnt) begin
      r_starve <= r_starve + 1'b1;
    end
  end
`else
  // Fairness compiled out: constant false, logic never pre-empts video
  assign w_fairForce = (MAX_STARVE < 0);
`endif

  always_comb begin
    vid_gnt     = 1'b0;
    lg_gnt      = 1'b0;
    mem_wr_en   = 1'b0;
    mem_addr    = vid_addr;
    mem_data_in = 1'b0;
    if (r_state == ST_IDLE) begin
      if (vid_req && !w_fairForce) begin
        vid_gnt = 1'b1;
      end else if (lg_req) begin
        lg_gnt      = 1'b1;
        mem_addr    = lg_addr;
        mem_wr_en   = lg_we && w_lgInRange;
        mem_data_in = lg_wdata;
      end
    end else begin
      if (vid_req) begin
        vid_gnt = 1'b1;
      end else begin
        mem_wr_en = 1'b1;
        mem_addr  = r_clrCnt;
      end
    end
    // The SRAM must never see a write while the arbiter is being reset
    if (reset) begin
      mem_wr_en = 1'b0;
    end
  end

  always_ff @(posedge clk_74a) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_clrCnt   <= '0;
      r_clrBusy  <= 1'b0;
      r_clrDone  <= 1'b0;
      r_vidValid <= 1'b0;
      r_vidOor   <= 1'b0;
      r_lgValid  <= 1'b0;
      r_lgOor    <= 1'b0;
    end else begin
      r_vidValid <= vid_gnt;
      r_vidOor   <= !w_vidInRange;
      r_lgValid  <= lg_gnt && !lg_we;
      r_lgOor    <= !w_lgInRange;
      r_clrDone  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (clr_start) begin
            r_state   <= ST_CLEAR;
            r_clrCnt  <= '0;
            r_clrBusy <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (!vid_req) begin
            if (r_clrCnt == LP_LAST) begin
              r_state   <= ST_IDLE;
              r_clrCnt  <= '0;
              r_clrBusy <= 1'b0;
              r_clrDone <= 1'b1;
            end else begin
              r_clrCnt <= r_clrCnt + 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // SRAM data is passed straight through in the cycle after the grant
  assign vid_valid = r_vidValid;
  assign vid_data  = r_vidValid && !r_vidOor && mem_data_out;
  assign lg_rvalid = r_lgValid;
  assign lg_rdata  = r_lgValid && !r_lgOor && mem_data_out;
  assign clr_busy  = r_clrBusy;
  assign clr_done  = r_clrDone;

endmodule

// File: tb/tb_grid_mem_arbiter.sv
// Directed bench for grid_mem_arbiter with a behavioural 1-bit SRAM (registered read, write at clock edge).
// Fairness expectations switch on GRID_ARB_FAIRNESS_EN.
module tb_grid_mem_arbiter;

  localparam int DEPTH = 1200;
  localparam int AW    = 11;

  logic          clk_74a = 1'b0;
  logic          reset   = 1'b1;
  logic          vid_req = 1'b0;
  logic [AW-1:0] vid_addr = '0;
  logic          vid_gnt, vid_valid, vid_data;
  logic          lg_req = 1'b0, lg_we = 1'b0, lg_wdata = 1'b0;
  logic [AW-1:0] lg_addr = '0;
  logic          lg_gnt, lg_rvalid, lg_rdata;
  logic          clr_start = 1'b0;
  logic          clr_busy, clr_done;
  logic          mem_wr_en, mem_data_in;
  logic [AW-1:0] mem_addr;
  logic          mem_data_out;

  logic          mem [0:2047];
  logic          fillEn = 1'b0;
  logic          fillVal = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  grid_mem_arbiter #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .MAX_STARVE(8)) dut (
    .clk_74a(clk_74a), .reset(reset),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt),
    .vid_valid(vid_valid), .vid_data(vid_data),
    .lg_req(lg_req), .lg_we(lg_we), .lg_addr(lg_addr), .lg_wdata(lg_wdata),
    .lg_gnt(lg_gnt), .lg_rvalid(lg_rvalid), .lg_rdata(lg_rdata),
    .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out)
  );

  always #5 clk_74a = ~clk_74a;

  // SRAM model; cells above DEPTH-1 are filled with 1 so masked reads are visible
  always @(posedge clk_74a) begin
    if (fillEn) begin
      for (int i = 0; i < 2048; i++) mem[i] <= (i >= DEPTH) ? 1'b1 : fillVal;
    end else if (mem_wr_en) begin
      mem[mem_addr] <= mem_data_in;
    end
    mem_data_out <= mem[mem_addr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic vr, input logic [AW-1:0] va, input logic lr,
                               input logic lw, input logic [AW-1:0] la, input logic ld,
                               input logic cs);
    vid_req = vr; vid_addr = va; lg_req = lr; lg_we = lw; lg_addr = la; lg_wdata = ld;
    clr_start = cs;
  endtask

  task automatic tick();
    @(posedge clk_74a);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic lgWrite(input logic [AW-1:0] a, input logic d);
    applyStimulus(1'b0, '0, 1'b1, 1'b1, a, d, 1'b0);
    tick();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic fillMem(input logic v);
    fillVal = v;
    fillEn  = 1'b1;
    tick();
    fillEn  = 1'b0;
  endtask

  function automatic int countOnes();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] === 1'b1) n++;
    return n;
  endfunction

  int busyCnt, gntCnt, wrCnt, doneCnt, vvCnt, kk;
  logic expLg;

  initial begin
    // Reset with a logic write held on the bus: nothing may reach the SRAM
    applyStimulus(1'b0, '0, 1'b1, 1'b1, 11'd5, 1'b1, 1'b0);
    fillMem(1'b0);
    tick();
    checkOutput("rst_mem_wr_en", mem_wr_en, 0);
    checkOutput("rst_lg_rvalid", lg_rvalid, 0);
    checkOutput("rst_vid_valid", vid_valid, 0);
    checkOutput("rst_clr_busy", clr_busy, 0);
    checkOutput("rst_clr_done", clr_done, 0);
    checkOutput("rst_lg_rdata", lg_rdata, 0);
    checkOutput("rst_no_write", mem[5], 0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    reset = 1'b0;
    tick();

    // Logic write 1 to cell 5, then read it back
    applyStimulus(1'b0, '0, 1'b1, 1'b1, 11'd5, 1'b1, 1'b0);
    settle();
    checkOutput("wr5_gnt", lg_gnt, 1);
    checkOutput("wr5_we", mem_wr_en, 1);
    checkOutput("wr5_addr", mem_addr, 5);
    tick();
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 11'd5, 1'b0, 1'b0);
    settle();
    checkOutput("rd5_gnt", lg_gnt, 1);
    checkOutput("rd5_we", mem_wr_en, 0);
    tick();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    settle();
    checkOutput("rd5_rvalid", lg_rvalid, 1);
    checkOutput("rd5_rdata", lg_rdata, 1);
    tick();
    checkOutput("rd5_pulse_end", lg_rvalid, 0);

    // Video beats logic; logic is served the cycle video drops
    lgWrite(11'd7, 1'b1);
    lgWrite(11'd8, 1'b1);
    applyStimulus(1'b1, 11'd7, 1'b1, 1'b0, 11'd8, 1'b0, 1'b0);
    settle();
    checkOutput("both_vid_gnt", vid_gnt, 1);
    checkOutput("both_lg_gnt", lg_gnt, 0);
    checkOutput("both_addr", mem_addr, 7);
    tick();
    applyStimulus(1'b0, 11'd7, 1'b1, 1'b0, 11'd8, 1'b0, 1'b0);
    settle();
    checkOutput("after_lg_gnt", lg_gnt, 1);
    checkOutput("after_addr", mem_addr, 8);
    checkOutput("vid7_valid", vid_valid, 1);
    checkOutput("vid7_data", vid_data, 1);
    tick();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    settle();
    checkOutput("lg8_rvalid", lg_rvalid, 1);
    checkOutput("lg8_rdata", lg_rdata, 1);
    checkOutput("vid_pulse_end", vid_valid, 0);

    // Out-of-range video read: model cell holds 1, arbiter must return 0
    applyStimulus(1'b1, 11'd1500, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    settle();
    checkOutput("vidoor_valid", vid_valid, 1);
    checkOutput("vidoor_data", vid_data, 0);

    // Out-of-range logic write and read
    applyStimulus(1'b0, '0, 1'b1, 1'b1, 11'd1200, 1'b1, 1'b0);
    settle();
    checkOutput("oorw_gnt", lg_gnt, 1);
    checkOutput("oorw_we", mem_wr_en, 0);
    tick();
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 11'd1200, 1'b0, 1'b0);
    settle();
    checkOutput("oorr_gnt", lg_gnt, 1);
    tick();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    settle();
    checkOutput("oorr_rvalid", lg_rvalid, 1);
    checkOutput("oorr_rdata", lg_rdata, 0);
    checkOutput("oor_cells_ones", countOnes(), 3);

    // Full clear, started together with a logic write; logic read held throughout
    fillMem(1'b1);
    applyStimulus(1'b0, '0, 1'b1, 1'b1, 11'd3, 1'b0, 1'b1);
    settle();
    checkOutput("clrst_lg_gnt", lg_gnt, 1);
    checkOutput("clrst_busy", clr_busy, 0);
    tick();
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 11'd0, 1'b0, 1'b0);
    settle();
    busyCnt = 0; gntCnt = 0; wrCnt = 0; doneCnt = 0;
    for (int k = 0; k < 5000; k++) begin
      if (!clr_busy) break;
      busyCnt++;
      if (lg_gnt) gntCnt++;
      if (mem_wr_en) wrCnt++;
      if (clr_done) doneCnt++;
      tick();
    end
    checkOutput("clr_busy_cycles", busyCnt, 1200);
    checkOutput("clr_lg_gnt_during", gntCnt, 0);
    checkOutput("clr_writes", wrCnt, 1200);
    checkOutput("clr_done_during", doneCnt, 0);
    checkOutput("clr_done_pulse", clr_done, 1);
    checkOutput("clr_lg_gnt_after", lg_gnt, 1);
    tick();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    settle();
    checkOutput("clr_done_once", clr_done, 0);
    checkOutput("clr_rd0_rvalid", lg_rvalid, 1);
    checkOutput("clr_rd0_rdata", lg_rdata, 0);
    checkOutput("clr_cells_ones", countOnes(), 0);

    // Clear with video on every third cycle
    fillMem(1'b1);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    tick();
    busyCnt = 0; gntCnt = 0; wrCnt = 0; vvCnt = 0;
    for (int k = 0; k < 5000; k++) begin
      if (!clr_busy) break;
      applyStimulus((k % 3) == 0, 11'd1500, 1'b0, 1'b0, '0, 1'b0, 1'b0);
      settle();
      busyCnt++;
      if (vid_gnt) gntCnt++;
      if (mem_wr_en) wrCnt++;
      if (vid_valid) vvCnt++;
      tick();
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    checkOutput("vclr_busy_cycles", busyCnt, 1800);
    checkOutput("vclr_vid_gnts", gntCnt, 600);
    checkOutput("vclr_writes", wrCnt, 1200);
    checkOutput("vclr_vid_valids", vvCnt, 600);
    checkOutput("vclr_done", clr_done, 1);

    // Reset 500 cycles into a clear
    tick();
    fillMem(1'b1);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    tick();
    for (int k = 0; k < 500; k++) begin
      applyStimulus((k % 3) == 0, 11'd1500, 1'b0, 1'b0, '0, 1'b0, 1'b0);
      tick();
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    checkOutput("rclr_busy", clr_busy, 0);
    checkOutput("rclr_done", clr_done, 0);
    reset = 1'b0;
    doneCnt = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (clr_done || clr_busy) doneCnt++;
    end
    checkOutput("rclr_no_done", doneCnt, 0);
    checkOutput("rclr_cell0", mem[0], 0);
    checkOutput("rclr_cell1199", mem[1199], 1);

    // Video and logic both held high continuously
    applyStimulus(1'b1, 11'd10, 1'b1, 1'b0, 11'd20, 1'b0, 1'b0);
    settle();
    for (int k = 0; k < 27; k++) begin
`ifdef GRID_ARB_FAIRNESS_EN
      expLg = ((k % 9) == 8);
`else
      expLg = 1'b0;
`endif
      kk = k;
      checkOutput($sformatf("starve_lg_gnt_c%0d", kk), lg_gnt, expLg);
      checkOutput($sformatf("starve_vid_gnt_c%0d", kk), vid_gnt, !expLg);
      tick();
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
